// File: rtl/dcache_2way.sv
// Two-way set-associative write-back, write-allocate data cache with one LRU bit per set.
// Hits complete combinationally in IDLE; misses optionally write back the victim, then refill it.
module dcache_2way #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;
    localparam int LB_W   = OFF_W + 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SETS-1:0][1:0] valid_q;
    logic [SETS-1:0][1:0] dirty_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tags  [0:1][SETS];
    logic [LINE_W-1:0]    lines [0:1][SETS];
    logic                 victim_q;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [LB_W-1:0]   bit_base;
    logic              req;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              victim_way;
    logic              victim_dirty;
    logic [LINE_W-1:0] sel_line;
    logic              unused_addr_lsb;

    assign tag      = p1_addr_i[ADDR_W-1:IDX_W+OFF_W];
    assign idx      = p1_addr_i[IDX_W+OFF_W-1:OFF_W];
    assign word     = p1_addr_i[OFF_W-1:2];
    assign bit_base = {word, 5'b00000};
    assign req      = p1_MemRead_i | p1_MemWrite_i;

    assign unused_addr_lsb = ^p1_addr_i[1:0];

    assign hit0    = valid_q[idx][0] && (tags[0][idx] == tag);
    assign hit1    = valid_q[idx][1] && (tags[1][idx] == tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;

    assign sel_line  = hit_way ? lines[1][idx] : lines[0][idx];
    assign p1_data_o = hit ? sel_line[bit_base +: 32] : 32'h0;

    // Empty ways are filled before anything is evicted; otherwise the LRU way goes.
    always_comb begin
        if (!valid_q[idx][0]) begin
            victim_way = 1'b0;
        end else if (!valid_q[idx][1]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_q[idx];
        end
        victim_dirty = valid_q[idx][victim_way] & dirty_q[idx][victim_way];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                victim_q <= victim_way;
                if (req && hit) begin
                    lru_q[idx] <= ~hit_way;
                    if (p1_MemWrite_i) begin
                        dirty_q[idx][hit_way] <= 1'b1;
                    end
                end
            end
            if (state_q == REFILL && mem_ack_i) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req && hit && p1_MemWrite_i) begin
            lines[hit_way][idx][bit_base +: 32] <= p1_data_i;
        end
        if (state_q == REFILL && mem_ack_i) begin
            lines[victim_q][idx] <= mem_data_i;
            tags[victim_q][idx]  <= tag;
        end
    end

    always_comb begin
        state_d      = state_q;
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                p1_stall_o = req & ~hit;
                if (req && !hit) begin
                    state_d = victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tags[victim_q][idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = lines[victim_q][idx];
                if (mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed self-checking bench for dcache_2way: cold refill, store hit, writeback,
// LRU replacement and reset during a writeback, all with hand-computed expectations.
module tb_dcache_2way;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_addr_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    int checks = 0;
    int errors = 0;

    dcache_2way #(
        .ADDR_W(32),
        .LINE_W(256),
        .SETS  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_data_i    (p1_data_i),
        .p1_addr_i    (p1_addr_i),
        .p1_MemRead_i (p1_MemRead_i),
        .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_addr_i     = addr;
        p1_data_i     = data;
        #1;
    endtask

    task automatic stepCycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic ackMem(input logic [255:0] line);
        mem_data_i = line;
        mem_ack_i  = 1'b1;
        @(negedge clk_i);
        mem_ack_i  = 1'b0;
        #1;
    endtask

    function automatic logic [255:0] makeLine(input logic [31:0] w0, input logic [31:0] w1);
        logic [255:0] l;
        l = {8{32'h0F0F0F0F}};
        l[31:0]  = w0;
        l[63:32] = w1;
        return l;
    endfunction

    task automatic checkMem(input string tag, input logic en, input logic wr, input logic [31:0] addr);
        checkOutput({tag, "_en"}, 64'(mem_enable_o), 64'(en));
        checkOutput({tag, "_wr"}, 64'(mem_write_o), 64'(wr));
        checkOutput({tag, "_addr"}, 64'(mem_addr_o), 64'(addr));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i         = 1'b0;
        p1_data_i     = '0;
        p1_addr_i     = '0;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        mem_data_i    = '0;
        mem_ack_i     = 1'b0;

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst_stall", 64'(p1_stall_o), 64'd0);
        checkOutput("rst_en", 64'(mem_enable_o), 64'd0);
        checkOutput("rst_wr", 64'(mem_write_o), 64'd0);
        rst_i = 1'b1;

        // Cold load refills way0 of set 2.
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("cold_stall", 64'(p1_stall_o), 64'd1);
        checkOutput("cold_idle_en", 64'(mem_enable_o), 64'd0);
        stepCycle();
        checkMem("cold_refill", 1'b1, 1'b0, 32'h40);
        checkOutput("cold_refill_stall", 64'(p1_stall_o), 64'd1);
        ackMem(makeLine(32'h11111111, 32'h01010101));
        checkOutput("cold_done_stall", 64'(p1_stall_o), 64'd1);
        checkOutput("cold_done_en", 64'(mem_enable_o), 64'd0);
        stepCycle();
        checkOutput("cold_hit_stall", 64'(p1_stall_o), 64'd0);
        checkOutput("cold_hit_data", 64'(p1_data_o), 64'h11111111);

        applyStimulus(1'b0, 1'b1, 32'h44, 32'hDEADBEEF);
        checkOutput("st_stall", 64'(p1_stall_o), 64'd0);
        checkOutput("st_en", 64'(mem_enable_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
        checkOutput("st_readback", 64'(p1_data_o), 64'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("st_word0_intact", 64'(p1_data_o), 64'h11111111);
        applyStimulus(1'b1, 1'b0, 32'h48, 32'h0);
        checkOutput("word2_select", 64'(p1_data_o), 64'h0F0F0F0F);

        // Second tag in set 2 goes into empty way1 with no writeback.
        applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
        checkOutput("w1_stall", 64'(p1_stall_o), 64'd1);
        stepCycle();
        checkMem("w1_refill", 1'b1, 1'b0, 32'h240);
        ackMem(makeLine(32'h33333333, 32'h0));
        stepCycle();
        checkOutput("w1_hit_data", 64'(p1_data_o), 64'h33333333);
        checkOutput("w1_hit_stall", 64'(p1_stall_o), 64'd0);

        // Third tag evicts dirty way0 (LRU) through a writeback.
        applyStimulus(1'b1, 1'b0, 32'h440, 32'h0);
        checkOutput("wb_stall", 64'(p1_stall_o), 64'd1);
        stepCycle();
        checkMem("wb", 1'b1, 1'b1, 32'h40);
        checkOutput("wb_data_w1", 64'(mem_data_o[63:32]), 64'hDEADBEEF);
        checkOutput("wb_data_w0", 64'(mem_data_o[31:0]), 64'h11111111);
        stepCycle();
        checkMem("wb_hold", 1'b1, 1'b1, 32'h40);
        ackMem('0);
        checkMem("wb_refill", 1'b1, 1'b0, 32'h440);
        ackMem(makeLine(32'h44444444, 32'h0));
        stepCycle();
        checkOutput("wb_hit_data", 64'(p1_data_o), 64'h44444444);

        // LRU: touching 0x240 makes way0 (0x440) the victim for 0x40.
        applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
        checkOutput("lru_touch_240", 64'(p1_data_o), 64'h33333333);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("lru_40_miss", 64'(p1_stall_o), 64'd1);
        stepCycle();
        checkMem("lru_40_refill", 1'b1, 1'b0, 32'h40);
        ackMem(makeLine(32'h55555555, 32'h0));
        stepCycle();
        checkOutput("lru_40_data", 64'(p1_data_o), 64'h55555555);
        applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
        checkOutput("lru_240_still", 64'(p1_data_o), 64'h33333333);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("lru_40_touch", 64'(p1_stall_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h640, 32'h0);
        checkOutput("lru_640_miss", 64'(p1_stall_o), 64'd1);
        stepCycle();
        checkMem("lru_640_refill", 1'b1, 1'b0, 32'h640);
        ackMem(makeLine(32'h66666666, 32'h0));
        stepCycle();
        checkOutput("lru_640_data", 64'(p1_data_o), 64'h66666666);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("lru_40_kept_stall", 64'(p1_stall_o), 64'd0);
        checkOutput("lru_40_kept_data", 64'(p1_data_o), 64'h55555555);

        // Dirty both ways, then a miss starts a writeback that reset aborts.
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
        checkOutput("rw_st40_stall", 64'(p1_stall_o), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h648, 32'hA5A5A5A5);
        checkOutput("rw_st648_stall", 64'(p1_stall_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
        checkOutput("rw_240_evicted", 64'(p1_stall_o), 64'd1);
        stepCycle();
        checkMem("rw_wb", 1'b1, 1'b1, 32'h40);
        checkOutput("rw_wb_data", 64'(mem_data_o[31:0]), 64'hCAFEF00D);
        rst_i        = 1'b0;
        p1_MemRead_i = 1'b0;
        #1;
        checkOutput("rw_rst_en", 64'(mem_enable_o), 64'd0);
        checkOutput("rw_rst_wr", 64'(mem_write_o), 64'd0);
        checkOutput("rw_rst_stall", 64'(p1_stall_o), 64'd0);
        stepCycle();
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        checkOutput("post_rst_miss", 64'(p1_stall_o), 64'd1);
        stepCycle();
        checkMem("post_rst_refill", 1'b1, 1'b0, 32'h40);

        p1_MemRead_i = 1'b0;
        rst_i        = 1'b0;
        stepCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
